// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary serial adder: trit encodings, controller
// states and a trit validity helper.
package ternary_pkg;

    localparam int unsigned TRIT_W = 2;

    localparam logic [TRIT_W-1:0] TRIT_0   = 2'b00;
    localparam logic [TRIT_W-1:0] TRIT_1   = 2'b01;
    localparam logic [TRIT_W-1:0] TRIT_2   = 2'b10;
    localparam logic [TRIT_W-1:0] TRIT_INV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrlState_t;

    function automatic logic tritValid(input logic [TRIT_W-1:0] t);
        return t != TRIT_INV;
    endfunction

endpackage

// File: rtl/ternary_trit_adder.sv
// One-trit ternary full adder: s = (a + b + cin) mod 3, cout = (a + b + cin) >= 3.
module ternary_trit_adder
    import ternary_pkg::*;
(
    input  logic [TRIT_W-1:0] a,
    input  logic [TRIT_W-1:0] b,
    input  logic              cin,
    output logic [TRIT_W-1:0] s,
    output logic              cout
);

    logic [2:0] tritTotal;

    // Valid trits give a total of at most 5, so a single subtraction of 3 suffices.
    always_comb begin
        tritTotal = 3'(a) + 3'(b) + 3'(cin);
        s         = tritTotal[TRIT_W-1:0];
        cout      = 1'b0;
        if (tritTotal >= 3'd3) begin
            s    = 2'(tritTotal - 3'd3);
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/ternary_serial_adder_ctrl.sv
// Digit-serial ternary adder controller: captures two operands on start, screens
// invalid trits, then sequences one trit adder LSB-first with a registered carry.
module ternary_serial_adder_ctrl
    import ternary_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2*DIGITS-1:0]   a,
    input  logic [2*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [2*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int unsigned BUS_W = 2 * DIGITS;
    localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_TRIT = CNT_W'(DIGITS - 1);

    ctrlState_t        state;
    logic [CNT_W-1:0]  tritCnt;
    logic              carry;
    logic [BUS_W-1:0]  opA;
    logic [BUS_W-1:0]  opB;
    logic              operandBad;
    logic [TRIT_W-1:0] tritSum;
    logic              tritCarry;

    // Screen the live operands so an invalid request is rejected at capture time.
    always_comb begin
        operandBad = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (!tritValid(a[2*i +: 2]) || !tritValid(b[2*i +: 2]))
                operandBad = 1'b1;
        end
    end

    // Captured operands shift right each RUN cycle, so trit [tritCnt] is always at [1:0].
    ternary_trit_adder uTritAdder (
        .a    (opA[TRIT_W-1:0]),
        .b    (opB[TRIT_W-1:0]),
        .cin  (carry),
        .s    (tritSum),
        .cout (tritCarry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tritCnt <= '0;
            carry   <= 1'b0;
            opA     <= '0;
            opB     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opA   <= a;
                        opB   <= b;
                        carry <= cin;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        if (operandBad) begin
                            err   <= 1'b1;
                            sum   <= '0;
                            cout  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            tritCnt <= '0;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    sum   <= {tritSum, sum[BUS_W-1:TRIT_W]};
                    carry <= tritCarry;
                    opA   <= {TRIT_W'(0), opA[BUS_W-1:TRIT_W]};
                    opB   <= {TRIT_W'(0), opB[BUS_W-1:TRIT_W]};
                    if (tritCnt == LAST_TRIT) begin
                        cout  <= tritCarry;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        tritCnt <= tritCnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ternary_serial_adder_ctrl.sv
// Bench for ternary_serial_adder_ctrl: directed cases plus random operands checked
// against an integer-arithmetic model of base-3 addition.
module tb_ternary_serial_adder_ctrl;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned BUS_W  = 2 * DIGITS;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [BUS_W-1:0] a = '0;
    logic [BUS_W-1:0] b = '0;
    logic             cin = 1'b0;
    logic             busy;
    logic             done;
    logic [BUS_W-1:0] sum;
    logic             cout;
    logic             err;

    int total = 0;
    int bad   = 0;

    ternary_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Operands as base-3 integers; result digits recovered by repeated division.
    function automatic void refModel(input logic [BUS_W-1:0] ra, input logic [BUS_W-1:0] rb,
                                     input logic rc, output logic [BUS_W-1:0] eSum,
                                     output logic eCout, output logic eErr);
        int va = 0;
        int vb = 0;
        int w  = 1;
        int t;
        eErr  = 1'b0;
        eSum  = '0;
        eCout = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (ra[2*i +: 2] == 2'b11 || rb[2*i +: 2] == 2'b11) eErr = 1'b1;
            va += int'(ra[2*i +: 2]) * w;
            vb += int'(rb[2*i +: 2]) * w;
            w  *= 3;
        end
        if (eErr) return;
        t = va + vb + int'(rc);
        for (int i = 0; i < int'(DIGITS); i++) begin
            eSum[2*i +: 2] = 2'(t % 3);
            t = t / 3;
        end
        eCout = (t != 0);
    endfunction

    task automatic runOp(input logic [BUS_W-1:0] ta, input logic [BUS_W-1:0] tbv,
                         input logic tc, input string tag);
        logic [BUS_W-1:0] es;
        logic ec, ee;
        int n;
        refModel(ta, tbv, tc, es, ec, ee);
        @(negedge clk);
        a = ta; b = tbv; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = BUS_W'($urandom);
        b = BUS_W'($urandom);
        cin = 1'($urandom);
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 32'(n), ee ? 32'd1 : 32'(DIGITS + 1));
        check({tag, " sum"}, 32'(sum), 32'(es));
        check({tag, " cout"}, 32'(cout), 32'(ec));
        check({tag, " err"}, 32'(err), 32'(ee));
        check({tag, " busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " busy_fall"}, 32'(busy), 32'd0);
        check({tag, " sum_hold"}, 32'(sum), 32'(es));
    endtask

    initial begin
        logic [BUS_W-1:0] ra, rb, es;
        logic ec, ee;
        int pulses, last;

        repeat (3) @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst sum", 32'(sum), 32'd0);
        check("rst cout", 32'(cout), 32'd0);
        check("rst err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        runOp(8'b00000110, 8'b00001001, 1'b0, "five_plus_seven");
        runOp(8'b10101010, 8'b00000001, 1'b0, "wrap_to_cout");
        runOp(8'h00, 8'h00, 1'b1, "cin_only");
        runOp(8'b11000000, 8'h00, 1'b0, "invalid_a");
        runOp(8'h00, 8'b00001100, 1'b0, "invalid_b");
        runOp(8'b10101010, 8'b10101010, 1'b1, "max_sum");

        // start held high: only one accept per operation, next accept after DONE->IDLE
        refModel(8'b00000110, 8'b00001001, 1'b0, es, ec, ee);
        @(negedge clk);
        a = 8'b00000110; b = 8'b00001001; cin = 1'b0; start = 1'b1;
        pulses = 0;
        last = -100;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (pulses == 1) check("held first", 32'(c), 32'd5);
                else check("held spacing", 32'(c - last), 32'd6);
                check("held sum", 32'(sum), 32'(es));
                last = c;
            end
        end
        start = 1'b0;
        check("held pulses", 32'(pulses), 32'd3);
        @(negedge clk);

        // asynchronous reset in the middle of RUN
        a = 8'b10101010; b = 8'b10101010; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst sum", 32'(sum), 32'd0);
        check("midrst cout", 32'(cout), 32'd0);
        check("midrst err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runOp(8'b00000110, 8'b00001001, 1'b0, "after_reset");

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                ra[2*i +: 2] = 2'($urandom_range(0, 2));
                rb[2*i +: 2] = 2'($urandom_range(0, 2));
            end
            if ($urandom_range(0, 9) == 0) ra[2*$urandom_range(0, DIGITS-1) +: 2] = 2'b11;
            if ($urandom_range(0, 9) == 0) rb[2*$urandom_range(0, DIGITS-1) +: 2] = 2'b11;
            runOp(ra, rb, 1'($urandom), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ternary_serial_adder_ctrl.md
# ternary_serial_adder_ctrl

Digit-serial controller that adds two DIGITS-trit ternary operands by sequencing a single one-trit full adder, least-significant trit first. Carry is registered between trits. Operands are captured on a start handshake, invalid trit encodings are screened, and a done pulse is produced with the held result. It sits between operand registers and result consumers wherever a multi-trit ternary sum is needed without a full ripple array.

## Interface
- DIGITS, 4, operand width in trits (≥2); each trit is 2 bits, bus width 2*DIGITS
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; accepted only in IDLE
- a  input  2*DIGITS  operand A, trit i at bits [2i+1:2i]
- b  input  2*DIGITS  operand B, same packing
- cin  input  1  initial carry into trit 0
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, result valid
- sum  output  2*DIGITS  result trits, same packing
- cout  output  1  carry out of trit DIGITS-1
- err  output  1  operand contained trit 2'b11

Trit encoding: 00=0, 01=1, 10=2, 11=invalid.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: capture a, b and cin into internal registers; clear err. If any trit of a or b is 11, set err=1, sum=0, cout=0 and go to DONE. Otherwise, clear the trit counter and go to RUN.
- RUN: each cycle, add trit [counter] of A and B plus the carry register.
  - Carry register ← trit carry-out.
  - Sum shift register shifts right by 2, and the new trit enters at bits [2*DIGITS-1:2*DIGITS-2].
  - Counter increments.
  - When counter = DIGITS-1, after that cycle's update go to DONE and load cout from the final carry.
- DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE (RUN or DONE) is ignored; nothing is queued.
- sum, cout and err hold their values from the end of one operation until the next accepted start.
- Arithmetic is modulo 3 per trit; the carry is 0 or 1. The maximum trit sum is 2+2+1=5, which gives trit 2 with carry 1.
- The counter is $clog2(DIGITS) bits and never wraps past DIGITS-1.
- Reset (at any time, including mid-RUN) applies immediately:
  - state=IDLE
  - busy=0, done=0
  - sum=0, cout=0, err=0
  - carry, counter and captured operands cleared

## Timing
- start sampled at edge k (state IDLE).
- Valid operands:
  - RUN covers cycles k+1 … k+DIGITS.
  - done is high in cycle k+DIGITS+1.
  - Latency is DIGITS+1 cycles from start to done.
- Invalid operands: done is high in cycle k+1.
- busy goes high in cycle k+1 and falls when the state returns to IDLE.
- Throughput: a new start is accepted no earlier than cycle k+DIGITS+2 (valid case).
- sum and cout are valid in the done cycle and stay stable after it.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package ternary_pkg holds:
  - trit constants TRIT_0, TRIT_1, TRIT_2, TRIT_INV
  - state enum {IDLE, RUN, DONE}
  - a trit-valid helper function
- Sub-module: ternary_trit_adder, a purely combinational one-trit full adder (2-bit a, 2-bit b, cin → 2-bit s, cout), instantiated once.
- The controller owns the FSM, counter, carry register, operand registers and sum shift register.

## Test plan
- DIGITS=4, a=8'b00000110 (5), b=8'b00001001 (7), cin=0, start at k → done at k+5, sum=8'b00010100 (12), cout=0, err=0.
- a=8'b10101010 (80), b=8'b00000001, cin=0 → sum=8'h00, cout=1 at k+5.
- a=8'h00, b=8'h00, cin=1 → sum=8'b00000001, cout=0.
- a=8'b11000000, b=8'h00 → done at k+1, err=1, sum=0, cout=0, busy back to 0 at k+2.
- start held high through the entire operation → exactly one done per accepted start, spaced 6 cycles apart; start asserted in DONE is ignored.
- rst_n asserted at k+2 mid-RUN → all outputs 0 immediately. After release, a fresh start with (5, 7) gives the correct result 5 cycles later.
